// File: rtl/mem_burst_master.sv
`default_nettype none
// ============================================================================
// Module      : mem_burst_master
// Description : Burst initiator for a single-port data memory. Executes
//               write bursts (stream in -> memory) and read bursts
//               (memory -> registered stream out) of 0..2**ADDR_W words.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_burst_master #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  // command channel
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [ADDR_W:0]   i_cmd_len,
  // write stream
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [DATA_W-1:0] i_wr_data,
  // read stream
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic [DATA_W-1:0] o_rd_data,
  // status
  output logic              o_busy,
  output logic              o_done,
  // memory port
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] c_LEN_ZERO = '0;
  localparam logic [ADDR_W:0] c_LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cur_addr;
  logic [ADDR_W:0]     r_remain;
  logic                r_rd_valid;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_done;

  logic                w_wr_hs;
  logic                w_rd_slot;

  // Handshake qualifiers: a write word lands this cycle, or the read output
  // register is free to take a new word (empty or being consumed).
  assign w_wr_hs   = (r_state == S_WRITE) && i_wr_valid;
  assign w_rd_slot = !r_rd_valid || i_rd_ready;

  // Burst sequencer: command capture, address/count stepping, read register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cur_addr <= '0;
      r_remain   <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            r_cur_addr <= i_cmd_addr;
            r_remain   <= i_cmd_len;
            if (i_cmd_len == c_LEN_ZERO) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else if (i_cmd_write) begin
              r_state <= S_WRITE;
            end else begin
              r_state <= S_READ;
            end
          end
        end
        S_WRITE: begin
          if (w_wr_hs) begin
            r_cur_addr <= r_cur_addr + 1'b1;
            r_remain   <= r_remain - 1'b1;
            if (r_remain == c_LEN_ONE) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (w_rd_slot) begin
            if (r_remain != c_LEN_ZERO) begin
              // Memory is async-read, so mem_rdata already reflects cur_addr.
              r_rd_data  <= i_mem_rdata;
              r_rd_valid <= 1'b1;
              r_cur_addr <= r_cur_addr + 1'b1;
              r_remain   <= r_remain - 1'b1;
            end else begin
              // Final word has been consumed; close out the burst.
              r_rd_valid <= 1'b0;
              r_state    <= S_DONE;
              r_done     <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Port decodes: only WRITE may touch memory; commands only taken in IDLE.
  always_comb begin
    o_cmd_ready = (r_state == S_IDLE);
    o_busy      = (r_state != S_IDLE);
    o_wr_ready  = (r_state == S_WRITE);
    o_mem_we    = w_wr_hs;
    o_mem_wdata = i_wr_data;
    o_mem_addr  = r_cur_addr;
    o_rd_valid  = r_rd_valid;
    o_rd_data   = r_rd_data;
    o_done      = r_done;
  end

endmodule
`default_nettype wire
